regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clr_seq.sv | 70 +++++++
 rtl/regfile_mp.sv | 115 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default parameter set for the multi-port
// register file and its clear sequencer.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;
    localparam int DEF_NWR   = 2;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: sweeps register indices 1..NREGS-1, one per cycle, on a
// clear request. The register file zeroes the indexed entry while clr_en_o
// is high. A one-cycle clr_done_o pulse follows the last swept index.
//
// state     | meaning
// ----------+--------------------------------------------------------
// CLR_IDLE  | waiting for clr_req_i
// CLR_SWEEP | zeroing entry clr_addr_o this cycle; counter advances
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int  NREGS = DEF_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req_i,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          clr_done_o
);

    localparam logic [AW-1:0] LastAddr = AW'(NREGS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // State, sweep counter and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; x0 is hardwired zero so the sweep starts at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_req_i) begin
                    state_d = CLR_SWEEP;
                    cnt_d   = AW'(1);
                end
            end
            CLR_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = CLR_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign clr_en_o   = (state_q == CLR_SWEEP);
    assign clr_addr_o = cnt_q;
    assign clr_done_o = done_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, a per-register
// busy scoreboard (set on issue, cleared on write) and a sequenced clear.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the resulting busy state) to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN  = DEF_XLEN,
    parameter int  NREGS = DEF_NREGS,
    parameter int  NRD   = DEF_NRD,
    parameter int  NWR   = DEF_NWR,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic             clr_en;
    logic [AW-1:0]    clr_addr;

    regfile_clr_seq #(
        .NREGS (NREGS)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (clr_req & ~clr_en),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr),
        .clr_done_o (clr_done)
    );

    assign clr_busy = clr_en;

    // Storage and scoreboard update. During a sweep only the sweep writes;
    // otherwise higher write ports override lower ones and an issue overrides
    // a same-cycle write so the newer producer keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (clr_en) begin
            regs_d[clr_addr] = '0;
            busy_d[clr_addr] = 1'b0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (waddr[k*AW +: AW] != '0)) begin
                    regs_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
                    busy_d[waddr[k*AW +: AW]] = 1'b0;
                end
            end
            if (iss_valid && (iss_addr != '0)) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
    end

    // Register file and busy bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = raddr[j*AW +: AW];

        // Read mux for port j; address 0 always reads as zero and never busy.
        always_comb begin
            rd = regs_q[ra];
            rb = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (rst_n && !clr_en) begin
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && (waddr[k*AW +: AW] == ra)) begin
                        rd = wdata[k*XLEN +: XLEN];
                        rb = iss_valid && (iss_addr == ra);
                    end
                end
            end
`endif
            if (ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata[j*XLEN +: XLEN] = rd;
        assign rbusy[j]              = rb;
    end

endmodule
